// File: rtl/eqed_pkg.sv
// ----------------------------------------------------------------------------
// eqed_pkg
// Shared definitions for the E-QED signature capture controller:
//   - state_e     : controller state encoding
//   - misr_seed() : MISR seed value (all zero except the LSB)
// ----------------------------------------------------------------------------
package eqed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Seed for a MISR of sig_w bits; callers truncate to their own width.
    // A zero-width MISR has no LSB to set.
    function automatic logic [63:0] misr_seed(input int unsigned sig_w);
        logic [63:0] v;
        v = 64'd0;
        if (sig_w != 32'd0) begin
            v[0] = 1'b1;
        end else begin
            v[0] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/eqed_misr.sv
// ----------------------------------------------------------------------------
// eqed_misr
// Multiple-input signature register. Stage 0 is the MSB of o_sig and
// stage SIG_W-1 is the LSB. Each enabled cycle the register shifts one
// stage towards the LSB, stage 0 takes the feedback of the last two stages
// XOR d[0], and every even stage k>=2 with k/2 < DATA_W also folds in d[k/2].
//
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-low reset (register loads the seed)
//   i_load_seed synchronous load of the seed value (wins over i_en)
//   i_en        compaction enable
//   i_d         DATA_W data bits, bit 0 = primary tap
//   o_sig       current signature
// ----------------------------------------------------------------------------
module eqed_misr
    import eqed_pkg::*;
#(
    parameter int SIG_W  = 6,
    parameter int DATA_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_seed,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [SIG_W-1:0]  o_sig
);

    localparam logic [SIG_W-1:0] SEED = SIG_W'(misr_seed(SIG_W));

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;
    logic [SIG_W-1:0] w_d_ext;

    // Zero-extended data so stages beyond the data width fold in a zero.
    assign w_d_ext = {{(SIG_W-DATA_W){1'b0}}, i_d};

    // Next-signature computation: seed load, compaction step, or hold.
    always_comb begin
        w_sig_next = r_sig;
        if (i_load_seed) begin
            w_sig_next = SEED;
        end else if (i_en) begin
            // stage 0 lives at bit SIG_W-1; stage k at bit SIG_W-1-k
            w_sig_next[SIG_W-1] = r_sig[1] ^ r_sig[0] ^ w_d_ext[0];
            for (int k = 1; k < SIG_W; k++) begin
                if ((k % 2) == 0) begin
                    w_sig_next[SIG_W-1-k] = r_sig[SIG_W-k] ^ w_d_ext[k/2];
                end else begin
                    w_sig_next[SIG_W-1-k] = r_sig[SIG_W-k];
                end
            end
        end else begin
            w_sig_next = r_sig;
        end
    end

    // Signature register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sig <= SEED;
        end else begin
            r_sig <= w_sig_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/eqed_capture_ctrl.sv
// ----------------------------------------------------------------------------
// eqed_capture_ctrl
// E-QED signature capture controller. Sequences one self-consistency check:
// holds the DUT in reset, seeds two MISRs, compacts DUT inputs/outputs for
// a programmable window, freezes the signatures and compares them against
// golden values.
//
// Ports:
//   i_clk          clock
//   i_rst          asynchronous active-low reset
//   i_start        begin a check (honoured in IDLE or DONE)
//   i_abort        return to IDLE from any state, no done/pass
//   i_window_len   capture cycles, latched on accepted start
//   i_gold_in_sig  expected input signature, latched on accepted start
//   i_gold_out_sig expected output signature, latched on accepted start
//   i_dut_in       DUT input bits (bit 0 = primary tap)
//   i_dut_out      DUT output bits (bit 0 = primary tap)
//   o_dut_rst      synchronous active-high reset to the DUT
//   o_busy         high in SEED, CAPTURE, CHECK
//   o_done         high in DONE
//   o_pass         valid while done: both signatures matched
//   o_in_sig       current/frozen input signature
//   o_out_sig      current/frozen output signature
// ----------------------------------------------------------------------------
module eqed_capture_ctrl
    import eqed_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3,
    parameter int SIG_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_window_len,
    input  logic [SIG_W-1:0] i_gold_in_sig,
    input  logic [SIG_W-1:0] i_gold_out_sig,
    input  logic [IN_W-1:0]  i_dut_in,
    input  logic [OUT_W-1:0] i_dut_out,
    output logic             o_dut_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [SIG_W-1:0] o_in_sig,
    output logic [SIG_W-1:0] o_out_sig
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W-1:0] r_cnt;
    logic [SIG_W-1:0] r_gold_in;
    logic [SIG_W-1:0] r_gold_out;
    logic             r_dut_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_pass_next;
    logic             w_misr_load;
    logic             w_misr_en;
    logic             w_sig_match;
    logic [SIG_W-1:0] w_in_sig;
    logic [SIG_W-1:0] w_out_sig;

    assign w_sig_match = (w_in_sig == r_gold_in) && (w_out_sig == r_gold_out);

    // Next-state, start acceptance and pass decode; abort overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_SEED;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SEED: begin
                if (r_win == CNT_ZERO) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // r_win is non-zero here, so r_win-1 cannot underflow
                if (r_cnt == (r_win - CNT_ONE)) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (i_start) begin
                    w_state_next = ST_SEED;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (i_abort) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
        end else begin
            w_accept     = w_accept;
        end

        // pass is captured on CHECK->DONE and held only while staying in DONE
        if (w_state_next != ST_DONE) begin
            w_pass_next = 1'b0;
        end else if (r_state == ST_CHECK) begin
            w_pass_next = w_sig_match;
        end else begin
            w_pass_next = r_pass;
        end
    end

    // MISRs only act when no abort is pending, so an abort freezes them.
    assign w_misr_load = (r_state == ST_SEED)    && !i_abort;
    assign w_misr_en   = (r_state == ST_CAPTURE) && !i_abort;

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_dut_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dut_rst <= (w_state_next == ST_IDLE) || (w_state_next == ST_SEED);
            r_busy    <= (w_state_next == ST_SEED) || (w_state_next == ST_CAPTURE)
                      || (w_state_next == ST_CHECK);
            r_done    <= (w_state_next == ST_DONE);
            r_pass    <= w_pass_next;
        end
    end

    // Latched window length and golden signatures.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_win      <= CNT_ZERO;
            r_gold_in  <= {SIG_W{1'b0}};
            r_gold_out <= {SIG_W{1'b0}};
        end else if (w_accept) begin
            r_win      <= i_window_len;
            r_gold_in  <= i_gold_in_sig;
            r_gold_out <= i_gold_out_sig;
        end else begin
            r_win      <= r_win;
            r_gold_in  <= r_gold_in;
            r_gold_out <= r_gold_out;
        end
    end

    // Capture-cycle counter: cleared in SEED, counts in CAPTURE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= CNT_ZERO;
        end else if (r_state == ST_SEED) begin
            r_cnt <= CNT_ZERO;
        end else if (r_state == ST_CAPTURE) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    eqed_misr #(
        .SIG_W  (SIG_W),
        .DATA_W (IN_W)
    ) u_in_misr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load_seed (w_misr_load),
        .i_en        (w_misr_en),
        .i_d         (i_dut_in),
        .o_sig       (w_in_sig)
    );

    eqed_misr #(
        .SIG_W  (SIG_W),
        .DATA_W (OUT_W)
    ) u_out_misr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load_seed (w_misr_load),
        .i_en        (w_misr_en),
        .i_d         (i_dut_out),
        .o_sig       (w_out_sig)
    );

    assign o_dut_rst = r_dut_rst;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_in_sig  = w_in_sig;
    assign o_out_sig = w_out_sig;

endmodule

// File: tb/tb_eqed_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_eqed_capture_ctrl
// Directed table-driven bench for eqed_capture_ctrl with hand-computed
// signatures, plus hand-written sequences for abort, busy-start, combined
// start/abort and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_eqed_capture_ctrl;

    localparam int IN_W  = 2;
    localparam int OUT_W = 3;
    localparam int SIG_W = 6;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] window_len;
    logic [SIG_W-1:0] gold_in_sig;
    logic [SIG_W-1:0] gold_out_sig;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             dut_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] in_sig;
    logic [SIG_W-1:0] out_sig;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [CNT_W-1:0] win;
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] dout;
        logic [SIG_W-1:0] gold_in;
        logic [SIG_W-1:0] gold_out;
        logic [SIG_W-1:0] exp_in;
        logic [SIG_W-1:0] exp_out;
        logic             exp_pass;
        bit               poke;
    } vec_t;

    vec_t vecs[7];

    eqed_capture_ctrl #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SIG_W (SIG_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_window_len   (window_len),
        .i_gold_in_sig  (gold_in_sig),
        .i_gold_out_sig (gold_out_sig),
        .i_dut_in       (dut_in),
        .i_dut_out      (dut_out),
        .o_dut_rst      (dut_rst),
        .o_busy         (busy),
        .o_done         (done),
        .o_pass         (pass),
        .o_in_sig       (in_sig),
        .o_out_sig      (out_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge. Starts one check and follows it to DONE.
    task automatic run_vec(input string tag, input vec_t v);
        int  n;
        bit  got;
        window_len   = v.win;
        gold_in_sig  = v.gold_in;
        gold_out_sig = v.gold_out;
        dut_in       = v.din;
        dut_out      = v.dout;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        chk({tag, " seed dut_rst"}, 32'(dut_rst), 32'd1);
        chk({tag, " seed busy"}, 32'(busy), 32'd1);
        got = (done === 1'b1);
        while (!got && n < 400) begin
            // start pulses with a bogus window while busy must be ignored
            if (v.poke && (n == 2 || n == 3)) begin
                start      = 1'b1;
                window_len = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (n == 2) begin
                chk({tag, " dut_rst after seed"}, 32'(dut_rst), 32'd0);
            end
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, " done reached"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(v.win) + 32'd3);
        chk({tag, " in_sig"}, 32'(in_sig), 32'(v.exp_in));
        chk({tag, " out_sig"}, 32'(out_sig), 32'(v.exp_out));
        chk({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
        chk({tag, " busy in done"}, 32'(busy), 32'd0);
        // one more cycle: done and pass held, signatures frozen
        @(negedge clk);
        chk({tag, " done held"}, 32'(done), 32'd1);
        chk({tag, " pass held"}, 32'(pass), 32'(v.exp_pass));
        chk({tag, " in_sig frozen"}, 32'(in_sig), 32'(v.exp_in));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //          win     din    dout    gold_in    gold_out   exp_in     exp_out    pass  poke
        vecs[0] = '{8'd5,   2'b00, 3'b000, 6'b000010, 6'b000010, 6'b000010, 6'b000010, 1'b1, 1'b0};
        vecs[1] = '{8'd1,   2'b01, 3'b000, 6'b000000, 6'b100000, 6'b000000, 6'b100000, 1'b1, 1'b0};
        vecs[2] = '{8'd1,   2'b01, 3'b000, 6'b000001, 6'b100000, 6'b000000, 6'b100000, 1'b0, 1'b0};
        vecs[3] = '{8'd0,   2'b11, 3'b111, 6'b000001, 6'b000001, 6'b000001, 6'b000001, 1'b1, 1'b0};
        vecs[4] = '{8'd2,   2'b11, 3'b111, 6'b101100, 6'b001111, 6'b101100, 6'b001111, 1'b1, 1'b0};
        vecs[5] = '{8'd3,   2'b10, 3'b010, 6'b000110, 6'b000111, 6'b000110, 6'b000110, 1'b0, 1'b1};
        // zero data: 6-stage LFSR of period 63, so 255 steps == 3 steps
        vecs[6] = '{8'd255, 2'b00, 3'b000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 1'b1, 1'b1};

        rst          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        window_len   = 8'd0;
        gold_in_sig  = 6'd0;
        gold_out_sig = 6'd0;
        dut_in       = 2'd0;
        dut_out      = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset dut_rst", 32'(dut_rst), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset pass", 32'(pass), 32'd0);
        chk("reset in_sig", 32'(in_sig), 32'h01);
        chk("reset out_sig", 32'(out_sig), 32'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("idle dut_rst", 32'(dut_rst), 32'd1);

        // table: each run after the first restarts from DONE with new values
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // abort in the 4th CAPTURE cycle of a 10-cycle window
        window_len = 8'd10;
        dut_in     = 2'b00;
        dut_out    = 3'b000;
        start      = 1'b1;
        @(negedge clk);                 // SEED
        start = 1'b0;
        repeat (4) @(negedge clk);      // CAPTURE cycles 1..4
        chk("abort pre busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort pass", 32'(pass), 32'd0);
        chk("abort dut_rst", 32'(dut_rst), 32'd1);
        chk("abort in_sig kept", 32'(in_sig), 32'h08);
        @(negedge clk);
        chk("abort stays idle", 32'(busy), 32'd0);
        run_vec("after abort", vecs[0]);

        // start and abort together in DONE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort done", 32'(done), 32'd0);
        chk("start+abort pass", 32'(pass), 32'd0);
        chk("start+abort dut_rst", 32'(dut_rst), 32'd1);

        // asynchronous reset mid-CAPTURE, dropped between clock edges
        window_len = 8'd10;
        dut_in     = 2'b11;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset dut_rst", 32'(dut_rst), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async dut_rst", 32'(dut_rst), 32'd1);
        chk("async busy", 32'(busy), 32'd0);
        chk("async in_sig", 32'(in_sig), 32'h01);
        chk("async out_sig", 32'(out_sig), 32'h01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle busy", 32'(busy), 32'd0);
        run_vec("after reset", vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
